// File: rtl/mux_pkg.sv
// Shared definitions for the 4-channel mux-select arbiter.
// Holds the channel count, FSM state encoding and default hold limit.
package mux_pkg;

    localparam int N_CH         = 4;
    localparam int MAX_HOLD_DEF = 15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_CH-1:0] dec4(input logic [1:0] idx);
        return (N_CH)'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-and-find-first over 4 requests.
// Returns the first set bit at or after start, wrapping 3 -> 0.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [1:0]      start,
    output logic            found,
    output logic [1:0]      idx
);

    always_comb begin
        found = 1'b0;
        idx   = 2'd0;
        // Walk backwards so the closest candidate to start wins.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[start + 2'(i)]) begin
                found = 1'b1;
                idx   = start + 2'(i);
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin grant arbiter with bounded hold time, driving a 4:1 mux select.
// gnt, sel and valid are all registered; sel holds its value while idle.
module mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] gnt,
    output logic [1:0]      sel,
    output logic            valid
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    state_t          state, nstate;
    logic [1:0]      ptr, nptr;
    logic [HW-1:0]   hold_cnt, nhold;
    logic [N_CH-1:0] ngnt;
    logic [1:0]      nsel;

    logic [N_CH-1:0] pick_req;
    logic [1:0]      pick_start;
    logic            pick_found;
    logic [1:0]      pick_idx;

    // One picker serves both paths: from ptr when idle, from sel+1
    // (excluding the current owner) when busy.
    always_comb begin
        if (state == BUSY) begin
            pick_req   = req & ~dec4(sel);
            pick_start = sel + 2'd1;
        end else begin
            pick_req   = req;
            pick_start = ptr;
        end
    end

    rr_pick4 u_pick (
        .req   (pick_req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        nstate = state;
        ngnt   = gnt;
        nsel   = sel;
        nptr   = ptr;
        nhold  = hold_cnt;
        unique case (state)
            IDLE: begin
                ngnt = '0;
                if (pick_found) begin
                    nstate = BUSY;
                    ngnt   = dec4(pick_idx);
                    nsel   = pick_idx;
                    nptr   = pick_idx + 2'd1;
                    nhold  = HW'(1);
                end
            end
            BUSY: begin
                if (req == '0) begin
                    nstate = IDLE;
                    ngnt   = '0;
                    nhold  = '0;
                end else if (req[sel] && hold_cnt < HOLD_MAX) begin
                    nhold = hold_cnt + HW'(1);
                end else if (pick_found) begin
                    // Owner dropped or used up its hold: hand over without a bubble.
                    ngnt  = dec4(pick_idx);
                    nsel  = pick_idx;
                    nptr  = pick_idx + 2'd1;
                    nhold = HW'(1);
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= 2'd0;
            valid    <= 1'b0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
        end else begin
            state    <= nstate;
            gnt      <= ngnt;
            sel      <= nsel;
            valid    <= (nstate == BUSY);
            ptr      <= nptr;
            hold_cnt <= nhold;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: two instances (MAX_HOLD 3 and 2)
// share clk/rst/req; each scenario checks the instance it targets.
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       valid_a, valid_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.MAX_HOLD(3)) dut_a (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .sel(sel_a), .valid(valid_a)
    );

    mux_sel_arbiter #(.MAX_HOLD(2)) dut_b (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .sel(sel_b), .valid(valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] seq [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                                 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        rst = 1'b1;
        req = 4'b1111;
        #2;

        // Reset dominates an all-ones request for three edges.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_gnt",   32'(gnt_a),   32'h0);
            chk("rst_sel",   32'(sel_a),   32'h0);
            chk("rst_valid", 32'(valid_a), 32'h0);
            chk("rst_gnt_b", 32'(gnt_b),   32'h0);
        end

        // Single request, one-cycle latency, then release holds sel.
        rst = 1'b0;
        req = 4'b0100;
        step();
        chk("single_gnt",   32'(gnt_a),   32'h4);
        chk("single_sel",   32'(sel_a),   32'h2);
        chk("single_valid", 32'(valid_a), 32'h1);
        req = 4'b0000;
        step();
        chk("release_valid", 32'(valid_a), 32'h0);
        chk("release_gnt",   32'(gnt_a),   32'h0);
        chk("release_sel",   32'(sel_a),   32'h2);
        step();
        chk("idle_sel_held", 32'(sel_a), 32'h2);

        // All requesting with MAX_HOLD=3: each channel keeps it 3 cycles.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            step();
            chk($sformatf("rr_sel[%0d]", i), 32'(sel_a), 32'(seq[i]));
            chk($sformatf("rr_valid[%0d]", i), 32'(valid_a), 32'h1);
        end

        // Owner drops while others pend: search after sel, no bubble.
        do_reset();
        req = 4'b0010;
        step();
        chk("hand_sel1",  32'(sel_a),   32'h1);
        req = 4'b1001;
        step();
        chk("hand_sel3",  32'(sel_a),   32'h3);
        chk("hand_gnt",   32'(gnt_a),   32'h8);
        chk("hand_valid", 32'(valid_a), 32'h1);

        // Reset pulse while channel 3 owns the grant.
        req = 4'b1000;
        step();
        chk("pre_rst_gnt", 32'(gnt_a), 32'h8);
        rst = 1'b1;
        step();
        chk("pulse_gnt",   32'(gnt_a),   32'h0);
        chk("pulse_sel",   32'(sel_a),   32'h0);
        chk("pulse_valid", 32'(valid_a), 32'h0);
        rst = 1'b0;
        step();
        chk("regrant_gnt",   32'(gnt_a),   32'h8);
        chk("regrant_sel",   32'(sel_a),   32'h3);
        chk("regrant_valid", 32'(valid_a), 32'h1);

        // Lone requester with MAX_HOLD=2: grant sticks, counter saturates.
        do_reset();
        req = 4'b0001;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("sat_gnt[%0d]", i), 32'(gnt_b), 32'h1);
            chk($sformatf("sat_hold[%0d]", i), 32'(dut_b.hold_cnt), (i < 2) ? 32'(i) : 32'h2);
        end

        // Same lone requester on the MAX_HOLD=3 instance also never drops.
        chk("sat_gnt_a", 32'(gnt_a), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
